// File: rtl/mpu_matrix_packer.sv
// Element-serial to parallel matrix packer: accepts an m x n dimension command, collects
// m*n elements in row-major order, then presents the packed array with a req/ack handshake.
module mpu_matrix_packer #(
    parameter int FP_WIDTH = 32,
    parameter int MAX_M    = 4,
    parameter int MAX_N    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [$clog2(MAX_M+1)-1:0]          cmd_m,
    input  logic [$clog2(MAX_N+1)-1:0]          cmd_n,
    input  logic                                elem_valid,
    output logic                                elem_ready,
    input  logic [FP_WIDTH-1:0]                 elem_data,
    output logic                                load_req,
    input  logic                                load_ack,
    output logic [$clog2(MAX_M+1)-1:0]          load_m,
    output logic [$clog2(MAX_N+1)-1:0]          load_n,
    output logic [MAX_M*MAX_N*FP_WIDTH-1:0]     load_matrix,
    output logic                                busy,
    output logic                                err_dim
);
    localparam int MW    = $clog2(MAX_M + 1);
    localparam int NW    = $clog2(MAX_N + 1);
    localparam int SLOTS = MAX_M * MAX_N;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [MW-1:0] m_reg, row_reg;
    logic [NW-1:0] n_reg, col_reg;
    logic          err_dim_reg;
    logic          dims_ok, cmd_accept, elem_accept, col_last, row_last;
    int            wr_idx;

    assign dims_ok = (cmd_m != '0) && (cmd_n != '0) &&
                     (cmd_m <= MW'(MAX_M)) && (cmd_n <= NW'(MAX_N));
    assign cmd_accept  = (state_reg == IDLE) && cmd_valid && dims_ok;
    assign elem_accept = (state_reg == FILL) && elem_valid;
    assign col_last    = (col_reg == n_reg - NW'(1));
    assign row_last    = (row_reg == m_reg - MW'(1));
    assign wr_idx      = int'(row_reg) * MAX_N + int'(col_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_accept) state_next = FILL;
            FILL:    if (elem_accept && col_last && row_last) state_next = PRESENT;
            PRESENT: if (load_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg       <= '0;
            n_reg       <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            err_dim_reg <= 1'b0;
        end else begin
            err_dim_reg <= (state_reg == IDLE) && cmd_valid && !dims_ok;
            if (cmd_accept) begin
                m_reg   <= cmd_m;
                n_reg   <= cmd_n;
                row_reg <= '0;
                col_reg <= '0;
            end else if (elem_accept) begin
                if (col_last) begin
                    col_reg <= '0;
                    row_reg <= row_last ? '0 : row_reg + MW'(1);
                end else begin
                    col_reg <= col_reg + NW'(1);
                end
            end
        end
    end

    // One register per slot; every slot clears on an accepted command so unused
    // positions of a smaller matrix read as zero.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [FP_WIDTH-1:0] slot_reg;
            always_ff @(posedge clk) begin
                if (rst || cmd_accept) begin
                    slot_reg <= '0;
                end else if (elem_accept && (wr_idx == gi)) begin
                    slot_reg <= elem_data;
                end
            end
            assign load_matrix[gi*FP_WIDTH +: FP_WIDTH] = slot_reg;
        end
    endgenerate

    assign cmd_ready  = (state_reg == IDLE);
    assign elem_ready = (state_reg == FILL);
    assign load_req   = (state_reg == PRESENT);
    assign busy       = (state_reg != IDLE);
    assign load_m     = m_reg;
    assign load_n     = n_reg;
    assign err_dim    = err_dim_reg;

endmodule

// File: tb/tb_mpu_matrix_packer.sv
// Scoreboard bench for mpu_matrix_packer: stimulus pushes model-built matrices, a monitor
// pops and compares them whenever load_req rises.
module tb_mpu_matrix_packer;
    localparam int FPW  = 32;
    localparam int MM   = 4;
    localparam int MN   = 4;
    localparam int SL   = MM * MN;
    localparam int MATW = SL * FPW;

    typedef logic [31:0] word_q_t[$];
    typedef struct {
        int              m;
        int              n;
        logic [MATW-1:0] mat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready;
    logic [2:0]      cmd_m, cmd_n;
    logic            elem_valid, elem_ready;
    logic [FPW-1:0]  elem_data;
    logic            load_req, load_ack;
    logic [2:0]      load_m, load_n;
    logic [MATW-1:0] load_matrix;
    logic            busy, err_dim;

    exp_t            sb_q[$];
    logic [MATW-1:0] last_mat;
    int              exp_err_pending = 0;
    int              check_cnt = 0;
    int              pass_cnt = 0;
    int              txn = 0;
    logic            prev_req = 1'b0;

    always #5 clk = ~clk;

    mpu_matrix_packer #(.FP_WIDTH(FPW), .MAX_M(MM), .MAX_N(MN)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_m(cmd_m), .cmd_n(cmd_n),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
        .load_req(load_req), .load_ack(load_ack), .load_m(load_m), .load_n(load_n),
        .load_matrix(load_matrix), .busy(busy), .err_dim(err_dim)
    );

    task automatic chk(input string name, input logic [MATW-1:0] act, input logic [MATW-1:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Reference: element k of the row-major stream lands at row k/n, column k%n.
    function automatic logic [MATW-1:0] model(input int m, input int n, input word_q_t e);
        logic [MATW-1:0] res = '0;
        for (int k = 0; k < m * n; k++)
            res[((k / n) * MN + (k % n)) * FPW +: FPW] = e[k];
        return res;
    endfunction

    function automatic word_q_t rand_words(input int k);
        word_q_t q;
        for (int i = 0; i < k; i++) q.push_back($urandom());
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int m, input int n, input word_q_t e);
        exp_t x;
        x.m = m;
        x.n = n;
        x.mat = model(m, n, e);
        last_mat = x.mat;
        sb_q.push_back(x);
    endtask

    task automatic send_cmd(input int m, input int n);
        cmd_m = 3'(m);
        cmd_n = 3'(n);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid toggles (ack pulsed in the gaps), 2: random stalls
    task automatic send_elems(input word_q_t e, input int mode);
        for (int i = 0; i < e.size(); i++) begin
            if (mode == 1 && i > 0) begin
                load_ack = 1'b1;
                tick();
                load_ack = 1'b0;
            end
            if (mode == 2) begin
                while ($urandom_range(0, 99) < 30) begin
                    load_ack = 1'($urandom_range(0, 1));
                    tick();
                    load_ack = 1'b0;
                end
            end
            chk("early_req", load_req, 0);
            chk("fill_elem_ready", elem_ready, 1);
            elem_valid = 1'b1;
            elem_data = e[i];
            tick();
            elem_valid = 1'b0;
        end
        chk("latency_req", load_req, 1);
    endtask

    task automatic finish_present(input int hold);
        for (int i = 0; i < hold; i++) begin
            chk("hold_req", load_req, 1);
            chk("hold_matrix", load_matrix, last_mat);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_elem_ready", elem_ready, 0);
            tick();
        end
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        chk("req_drop", load_req, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("matrix_kept", load_matrix, last_mat);
    endtask

    task automatic run_matrix(input int m, input int n, input int mode, input int hold);
        word_q_t e = rand_words(m * n);
        push_exp(m, n, e);
        send_cmd(m, n);
        send_elems(e, mode);
        finish_present(hold);
    endtask

    task automatic bad_cmd(input int m, input int n);
        exp_err_pending++;
        send_cmd(m, n);
        chk("err_pulse", err_dim, 1);
        chk("err_busy", busy, 0);
        chk("err_cmd_ready", cmd_ready, 1);
        tick();
        chk("err_one_cycle", err_dim, 0);
        chk("err_busy_after", busy, 0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (load_req && !prev_req) begin
                    if (sb_q.size() == 0) begin
                        check_cnt++;
                        $display("FAIL unexpected_load_req: got load_req=1 required no pending matrix");
                    end else begin
                        x = sb_q.pop_front();
                        txn++;
                        $display("txn %0d: %0dx%0d matrix presented", txn, x.m, x.n);
                        chk("load_m", load_m, x.m);
                        chk("load_n", load_n, x.n);
                        chk("load_matrix", load_matrix, x.mat);
                    end
                end
                prev_req = load_req;
                if (err_dim) begin
                    check_cnt++;
                    if (exp_err_pending > 0) begin
                        pass_cnt++;
                        exp_err_pending--;
                    end else begin
                        $display("FAIL unexpected_err_dim: got err_dim=1 required 0");
                    end
                end
            end
        end
    end

    initial begin : stimulus
        word_q_t e;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_m = '0;
        cmd_n = '0;
        elem_valid = 1'b0;
        elem_data = '0;
        load_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_load_req", load_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_elem_ready", elem_ready, 0);
        chk("rst_err_dim", err_dim, 0);
        chk("rst_load_m", load_m, 0);
        chk("rst_load_n", load_n, 0);
        chk("rst_matrix", load_matrix, 0);

        // 2x2 with fixed values, back-to-back
        e = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        push_exp(2, 2, e);
        send_cmd(2, 2);
        send_elems(e, 0);
        finish_present(1);

        // load_ack in IDLE has no effect
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        chk("ack_idle_busy", busy, 0);
        chk("ack_idle_cmd_ready", cmd_ready, 1);

        // 4x4 with toggling valid, then a long hold in PRESENT
        run_matrix(4, 4, 1, 10);

        // dimension errors
        bad_cmd(0, 2);
        bad_cmd(2, 5);
        bad_cmd(5, 1);
        bad_cmd(3, 0);

        // reset part-way through a 3x3 fill
        send_cmd(3, 3);
        e = rand_words(3);
        for (int i = 0; i < 3; i++) begin
            elem_valid = 1'b1;
            elem_data = e[i];
            tick();
        end
        elem_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_load_req", load_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_matrix", load_matrix, 0);
        chk("abort_load_m", load_m, 0);
        run_matrix(1, 1, 0, 0);

        // ack together with cmd_valid in PRESENT: command accepted one cycle later
        e = rand_words(6);
        push_exp(2, 3, e);
        send_cmd(2, 3);
        send_elems(e, 0);
        e = rand_words(4);
        load_ack = 1'b1;
        cmd_m = 3'd4;
        cmd_n = 3'd1;
        cmd_valid = 1'b1;
        tick();
        load_ack = 1'b0;
        chk("ackcmd_not_busy", busy, 0);
        chk("ackcmd_cmd_ready", cmd_ready, 1);
        chk("ackcmd_req_drop", load_req, 0);
        push_exp(4, 1, e);
        tick();
        cmd_valid = 1'b0;
        chk("ackcmd_busy", busy, 1);
        chk("ackcmd_elem_ready", elem_ready, 1);
        send_elems(e, 0);
        finish_present(2);

        // randomized traffic
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    bad_cmd($urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(5, 7)),
                            int'($urandom_range(1, 4)));
                else
                    bad_cmd(int'($urandom_range(1, 4)),
                            $urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(5, 7)));
            end
            run_matrix(int'($urandom_range(1, MM)), int'($urandom_range(1, MN)),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 4)));
        end

        repeat (2) tick();
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("err_drained", exp_err_pending, 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
